// File: rtl/reset_sequencer_if.sv
// Bundle between the reset sequencer and its requester/consumers: request and
// force inputs, staged per-domain resets, busy flag and issued-reset count.
interface reset_sequencer_if #(
  parameter int N_OUT = 4,
  parameter int CNT_W = 8
);
  logic             req_l;
  logic             force_req;
  logic [N_OUT-1:0] reset_l_out;
  logic             seq_busy;
  logic [CNT_W-1:0] reset_count;

  modport master (output req_l, force_req, input reset_l_out, seq_busy, reset_count);
  modport slave  (input req_l, force_req, output reset_l_out, seq_busy, reset_count);
endinterface

// File: rtl/reset_sequencer.sv
// Master reset sequencer: filters the active-low request, holds every domain in
// reset, then releases domains one at a time from bit 0 upward.
//
//   state      | meaning
//   -----------+---------------------------------------------------------------
//   ST_IDLE    | all domains out of reset, waiting for req_l low
//   ST_ARMING  | req_l low, counting consecutive low samples
//   ST_ARMED   | request long enough, waiting for it to be released
//   ST_ASSERT  | all domains held in reset for ASSERT_CYCLES
//   ST_RELEASE | domains released one per STAGE_GAP cycles
module reset_sequencer #(
  parameter int N_OUT         = 4,
  parameter int HOLD_CYCLES   = 10,
  parameter int ASSERT_CYCLES = 4,
  parameter int STAGE_GAP     = 2,
  parameter int CNT_W         = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  reset_sequencer_if.slave io_seq
);
  localparam int TMR_MAX = (ASSERT_CYCLES > STAGE_GAP) ? ASSERT_CYCLES : STAGE_GAP;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);

  localparam logic [TMR_W-1:0]  ASSERT_LOAD = TMR_W'(ASSERT_CYCLES - 1);
  localparam logic [TMR_W-1:0]  GAP_LOAD    = TMR_W'(STAGE_GAP - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD   = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMING,
    ST_ARMED,
    ST_ASSERT,
    ST_RELEASE
  } state_t;

  state_t             r_state;
  logic [TMR_W-1:0]   r_timer;
  logic [HOLD_W-1:0]  r_hold;
  logic [N_OUT-1:0]   r_out;
  logic               r_busy;
  logic [CNT_W-1:0]   r_count;

  state_t             w_state_nxt;
  logic [TMR_W-1:0]   w_timer_nxt;
  logic [HOLD_W-1:0]  w_hold_nxt;
  logic [N_OUT-1:0]   w_out_nxt;
  logic               w_count_inc;

  // r_hold counts the low samples still needed; r_timer is a shared down-counter
  // for the assert hold and the gap between domain releases.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_hold_nxt  = r_hold;
    w_out_nxt   = r_out;
    w_count_inc = 1'b0;

    if (io_seq.force_req) begin
      w_state_nxt = ST_ASSERT;
      w_timer_nxt = ASSERT_LOAD;
      w_hold_nxt  = '0;
      w_out_nxt   = '0;
      w_count_inc = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_out_nxt = '1;
          if (!io_seq.req_l) begin
            w_hold_nxt  = HOLD_LOAD;
            w_state_nxt = (HOLD_CYCLES == 1) ? ST_ARMED : ST_ARMING;
          end
        end
        ST_ARMING: begin
          if (io_seq.req_l) begin
            w_state_nxt = ST_IDLE;
            w_hold_nxt  = '0;
          end else if (r_hold == HOLD_W'(1)) begin
            w_state_nxt = ST_ARMED;
            w_hold_nxt  = '0;
          end else begin
            w_hold_nxt = r_hold - HOLD_W'(1);
          end
        end
        ST_ARMED: begin
          if (io_seq.req_l) begin
            w_state_nxt = ST_ASSERT;
            w_timer_nxt = ASSERT_LOAD;
            w_out_nxt   = '0;
            w_count_inc = 1'b1;
          end
        end
        ST_ASSERT: begin
          if (r_timer == '0) begin
            w_out_nxt   = N_OUT'(1);
            w_timer_nxt = GAP_LOAD;
            w_state_nxt = (w_out_nxt == '1) ? ST_IDLE : ST_RELEASE;
          end else begin
            w_timer_nxt = r_timer - TMR_W'(1);
          end
        end
        ST_RELEASE: begin
          // Released domains form a contiguous run from bit 0, so shift in a one.
          if (r_timer == '0) begin
            w_out_nxt   = (r_out << 1) | N_OUT'(1);
            w_timer_nxt = GAP_LOAD;
            w_state_nxt = (w_out_nxt == '1) ? ST_IDLE : ST_RELEASE;
          end else begin
            w_timer_nxt = r_timer - TMR_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_ASSERT;
      r_timer <= ASSERT_LOAD;
      r_hold  <= '0;
      r_out   <= '0;
      r_busy  <= 1'b1;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_hold  <= w_hold_nxt;
      r_out   <= w_out_nxt;
      r_busy  <= (w_state_nxt == ST_ASSERT) || (w_state_nxt == ST_RELEASE);
      if (w_count_inc && (r_count != '1)) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign io_seq.reset_l_out = r_out;
  assign io_seq.seq_busy    = r_busy;
  assign io_seq.reset_count = r_count;
endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed vector table, hand-written
// corner sequences and random stimulus against an elapsed-time reference model.
module tb_reset_sequencer;
  localparam int N    = 4;
  localparam int HOLD = 10;
  localparam int ASRT = 4;
  localparam int GAP  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  reset_sequencer_if #(.N_OUT(N), .CNT_W(8)) if_a ();
  reset_sequencer_if #(.N_OUT(N), .CNT_W(2)) if_b ();

  reset_sequencer #(.N_OUT(N), .HOLD_CYCLES(HOLD), .ASSERT_CYCLES(ASRT),
                    .STAGE_GAP(GAP), .CNT_W(8)) dut_a (
    .i_clk   (clk),
    .i_reset (rst),
    .io_seq  (if_a.slave)
  );

  reset_sequencer #(.N_OUT(N), .HOLD_CYCLES(HOLD), .ASSERT_CYCLES(ASRT),
                    .STAGE_GAP(GAP), .CNT_W(2)) dut_b (
    .i_clk   (clk),
    .i_reset (rst),
    .io_seq  (if_b.slave)
  );

  always #5 clk = ~clk;

  // Reference model: a sequence is "time since it started"; outputs follow from that.
  bit m_in_seq = 1'b1;
  int m_e      = 0;
  int m_low    = 0;
  bit m_armed  = 1'b0;
  int m_cnt    = 0;

  function automatic int released(input int e);
    int k;
    if (e < ASRT) return 0;
    k = (e - ASRT) / GAP + 1;
    return (k > N) ? N : k;
  endfunction

  task automatic model_step(input bit r, input bit req, input bit f);
    if (r) begin
      m_in_seq = 1'b1; m_e = 0; m_low = 0; m_armed = 1'b0; m_cnt = 0;
    end else if (f) begin
      m_in_seq = 1'b1; m_e = 0; m_low = 0; m_armed = 1'b0; m_cnt++;
    end else if (m_in_seq) begin
      m_e++;
      if (released(m_e) == N) begin
        m_in_seq = 1'b0; m_low = 0; m_armed = 1'b0;
      end
    end else if (m_armed) begin
      if (req) begin
        m_in_seq = 1'b1; m_e = 0; m_armed = 1'b0; m_cnt++;
      end
    end else if (!req) begin
      m_low++;
      if (m_low >= HOLD) m_armed = 1'b1;
    end else begin
      m_low = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp_v, $time);
    end
  endtask

  task automatic check_model();
    logic [N-1:0] e_out;
    e_out = m_in_seq ? N'((1 << released(m_e)) - 1) : '1;
    chk("out_a",  32'(if_a.reset_l_out), 32'(e_out));
    chk("busy_a", 32'(if_a.seq_busy),    32'(m_in_seq));
    chk("cnt_a",  32'(if_a.reset_count), (m_cnt > 255) ? 255 : m_cnt);
    chk("out_b",  32'(if_b.reset_l_out), 32'(e_out));
    chk("cnt_b",  32'(if_b.reset_count), (m_cnt > 3) ? 3 : m_cnt);
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic cycle(input bit r, input bit req, input bit f, input bit use_model);
    rst = r;
    if_a.req_l = req;  if_b.req_l = req;
    if_a.force_req = f; if_b.force_req = f;
    @(posedge clk);
    model_step(r, req, f);
    #1;
    if (use_model) check_model();
  endtask

  typedef struct {
    bit         r;
    bit         req;
    bit         f;
    logic [3:0] out;
    bit         busy;
    int         cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_n(input int n, input bit r, input bit req, input bit f,
                                input logic [3:0] out, input bit busy, input int cnt);
    vec_t v;
    v.r = r; v.req = req; v.f = f; v.out = out; v.busy = busy; v.cnt = cnt;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  initial begin
    if_a.req_l = 1'b1; if_b.req_l = 1'b1;
    if_a.force_req = 1'b0; if_b.force_req = 1'b0;

    // Power-on reset, staged release, glitch rejection, then a valid request.
    add_n(3,  1, 1, 0, 4'h0, 1, 0);
    add_n(3,  0, 1, 0, 4'h0, 1, 0);
    add_n(2,  0, 1, 0, 4'h1, 1, 0);
    add_n(2,  0, 1, 0, 4'h3, 1, 0);
    add_n(2,  0, 1, 0, 4'h7, 1, 0);
    add_n(2,  0, 1, 0, 4'hF, 0, 0);
    add_n(9,  0, 0, 0, 4'hF, 0, 0);
    add_n(1,  0, 1, 0, 4'hF, 0, 0);
    add_n(10, 0, 0, 0, 4'hF, 0, 0);
    add_n(4,  0, 1, 0, 4'h0, 1, 1);
    add_n(2,  0, 1, 0, 4'h1, 1, 1);
    add_n(2,  0, 1, 0, 4'h3, 1, 1);
    add_n(2,  0, 1, 0, 4'h7, 1, 1);
    add_n(1,  0, 1, 0, 4'hF, 0, 1);

    foreach (vecs[i]) begin
      cycle(vecs[i].r, vecs[i].req, vecs[i].f, 1'b0);
      chk($sformatf("vec%0d_out", i),  32'(if_a.reset_l_out), 32'(vecs[i].out));
      chk($sformatf("vec%0d_busy", i), 32'(if_a.seq_busy),    32'(vecs[i].busy));
      chk($sformatf("vec%0d_cnt_a", i), 32'(if_a.reset_count), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d_cnt_b", i), 32'(if_b.reset_count), 32'(vecs[i].cnt));
    end

    // Long request: nothing happens until it is released.
    repeat (30) cycle(0, 0, 0, 1);
    chk("long_req_out", 32'(if_a.reset_l_out), 32'hF);
    cycle(0, 1, 0, 1);
    chk("long_rel_out", 32'(if_a.reset_l_out), 32'h0);
    chk("long_rel_cnt", 32'(if_a.reset_count), 32'd2);
    repeat (12) cycle(0, 1, 0, 1);

    // Force mid-release re-asserts and restages.
    cycle(0, 1, 1, 1);
    repeat (6) cycle(0, 1, 0, 1);
    chk("mid_rel_out", 32'(if_a.reset_l_out), 32'h3);
    cycle(0, 1, 1, 1);
    chk("force_out", 32'(if_a.reset_l_out), 32'h0);
    chk("force_cnt", 32'(if_a.reset_count), 32'd4);
    repeat (3) cycle(0, 1, 0, 1);
    chk("force_hold", 32'(if_a.reset_l_out), 32'h0);
    cycle(0, 1, 0, 1);
    chk("force_restage", 32'(if_a.reset_l_out), 32'h1);
    repeat (8) cycle(0, 1, 0, 1);

    // Repeated force during ASSERT extends the hold and counts every pulse.
    cycle(0, 1, 1, 1);
    repeat (6) cycle(0, 1, 1, 1);
    chk("ext_cnt_a", 32'(if_a.reset_count), 32'd11);
    chk("ext_cnt_b", 32'(if_b.reset_count), 32'd3);
    repeat (3) cycle(0, 1, 0, 1);
    chk("ext_hold", 32'(if_a.reset_l_out), 32'h0);
    cycle(0, 1, 0, 1);
    chk("ext_release", 32'(if_a.reset_l_out), 32'h1);
    repeat (8) cycle(0, 1, 0, 1);

    // Saturation of the narrow counter, then block reset mid-release.
    cycle(1, 1, 0, 1);
    repeat (12) cycle(0, 1, 0, 1);
    for (int s = 0; s < 5; s++) begin
      cycle(0, 1, 1, 1);
      repeat (11) cycle(0, 1, 0, 1);
    end
    chk("sat_cnt_b", 32'(if_b.reset_count), 32'd3);
    chk("sat_cnt_a", 32'(if_a.reset_count), 32'd5);
    cycle(0, 1, 1, 1);
    repeat (6) cycle(0, 1, 0, 1);
    cycle(1, 1, 0, 1);
    chk("rst_mid_out", 32'(if_a.reset_l_out), 32'h0);
    chk("rst_mid_cnt_a", 32'(if_a.reset_count), 32'd0);
    chk("rst_mid_cnt_b", 32'(if_b.reset_count), 32'd0);
    repeat (12) cycle(0, 1, 0, 1);

    // Random request runs, occasional force and block reset.
    begin
      int hold_left = 0;
      bit req = 1'b1;
      bit r, f;
      for (int i = 0; i < 3000; i++) begin
        if (hold_left == 0) begin
          req = ~req;
          hold_left = $urandom_range(1, 16);
        end
        hold_left--;
        r = ($urandom_range(0, 299) == 0);
        f = ($urandom_range(0, 39) == 0);
        cycle(r, req, f, 1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
